// File: rtl/alu_instr_sequencer.sv
// Control-step sequencer for 3-register ALU instructions: fetch T0-T2, execute T3-T6.
// Latency: one clock per step; T1 stretches until mem_ready or MEM_TIMEOUT cycles, whichever is first.
// Backpressure: mem_ready is the only stall source; run is level-sensitive and never aborts an instruction.
//
// Ports:
//   Clock, clear_n          - rising-edge clock, asynchronous active-low reset
//   run                     - start / keep executing instructions
//   mem_ready               - memory data valid (sampled on the edge that opens each T1 cycle)
//   ir_in                   - IR contents {opcode, ra, rb, rc, ...}; sampled from the T2->T3 edge onward
//   PCout..MDRout           - bus drivers; MARin..LOin register loads; IncPC, Read
//   Rin / Rout              - one-hot register load / drive
//   alu_op                  - opcode presented to the ALU, held from T4 until the next T4
//   busy, done              - FSM active; one-cycle pulse in the final execute step
//   illegal, mem_fault      - sticky trap flags, cleared only by reset
//   instr_count             - retired instructions, wraps
module alu_instr_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int REG_SEL_W   = 4,
  parameter int OPC_W       = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int COUNT_W     = 16,
  localparam int NUM_REGS   = 2 ** REG_SEL_W
) (
  input  logic                  Clock,
  input  logic                  clear_n,
  input  logic                  run,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] ir_in,
  output logic                  PCout,
  output logic                  Zhighout,
  output logic                  Zlowout,
  output logic                  MDRout,
  output logic                  MARin,
  output logic                  Zin,
  output logic                  PCin,
  output logic                  MDRin,
  output logic                  IRin,
  output logic                  Yin,
  output logic                  HIin,
  output logic                  LOin,
  output logic                  IncPC,
  output logic                  Read,
  output logic [NUM_REGS-1:0]   Rin,
  output logic [NUM_REGS-1:0]   Rout,
  output logic [OPC_W-1:0]      alu_op,
  output logic                  busy,
  output logic                  done,
  output logic                  illegal,
  output logic                  mem_fault,
  output logic [COUNT_W-1:0]    instr_count
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6} state_t;
  typedef enum logic [1:0] {C_BIN, C_MULDIV, C_UNARY, C_ILLEGAL} op_class_t;

  state_t            state;
  op_class_t         cls;
  logic [WAIT_W-1:0] wait_cnt;

  logic [OPC_W-1:0]     opcode;
  logic [REG_SEL_W-1:0] ra, rb, rc;
  logic                 ir_unused;
  logic                 retire;
  logic                 start;

  assign opcode    = ir_in[DATA_WIDTH-1 -: OPC_W];
  assign ra        = ir_in[DATA_WIDTH-OPC_W-1 -: REG_SEL_W];
  assign rb        = ir_in[DATA_WIDTH-OPC_W-REG_SEL_W-1 -: REG_SEL_W];
  assign rc        = ir_in[DATA_WIDTH-OPC_W-2*REG_SEL_W-1 -: REG_SEL_W];
  assign ir_unused = ^ir_in;

  function automatic op_class_t classify(input logic [OPC_W-1:0] op);
    case (op)
      OPC_W'(5'b00011), OPC_W'(5'b00100), OPC_W'(5'b00101), OPC_W'(5'b00110),
      OPC_W'(5'b00111), OPC_W'(5'b01000), OPC_W'(5'b01001), OPC_W'(5'b01010): return C_BIN;
      OPC_W'(5'b01111), OPC_W'(5'b10000):                                     return C_MULDIV;
      OPC_W'(5'b10001), OPC_W'(5'b10010):                                     return C_UNARY;
      default:                                                                return C_ILLEGAL;
    endcase
  endfunction

  function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_SEL_W-1:0] sel);
    return NUM_REGS'(1) << sel;
  endfunction

  // retire: the step carrying done; start: the edge that enters T0 (from IDLE or straight
  // out of a retiring step, so back-to-back instructions see no IDLE cycle).
  always_comb begin
    retire = (state == S_T5 && cls != C_MULDIV) || (state == S_T6);
    start  = run && (state == S_IDLE || retire);
  end

  // Outputs are registered alongside the state they belong to, so every decision for a
  // step is taken on the edge that enters it (mem_ready for T1, the opcode class for T3).
  always_ff @(posedge Clock or negedge clear_n) begin
    if (!clear_n) begin
      state       <= S_IDLE;
      cls         <= C_BIN;
      wait_cnt    <= '0;
      PCout       <= 1'b0;
      Zhighout    <= 1'b0;
      Zlowout     <= 1'b0;
      MDRout      <= 1'b0;
      MARin       <= 1'b0;
      Zin         <= 1'b0;
      PCin        <= 1'b0;
      MDRin       <= 1'b0;
      IRin        <= 1'b0;
      Yin         <= 1'b0;
      HIin        <= 1'b0;
      LOin        <= 1'b0;
      IncPC       <= 1'b0;
      Read        <= 1'b0;
      Rin         <= '0;
      Rout        <= '0;
      alu_op      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      mem_fault   <= 1'b0;
      instr_count <= '0;
    end else begin
      PCout    <= 1'b0;
      Zhighout <= 1'b0;
      Zlowout  <= 1'b0;
      MDRout   <= 1'b0;
      MARin    <= 1'b0;
      Zin      <= 1'b0;
      PCin     <= 1'b0;
      MDRin    <= 1'b0;
      IRin     <= 1'b0;
      Yin      <= 1'b0;
      HIin     <= 1'b0;
      LOin     <= 1'b0;
      IncPC    <= 1'b0;
      Read     <= 1'b0;
      Rin      <= '0;
      Rout     <= '0;
      done     <= 1'b0;

      case (state)
        S_IDLE: ;
        S_T0: begin
          state    <= S_T1;
          Read     <= 1'b1;
          MDRin    <= mem_ready;
          wait_cnt <= WAIT_W'(1);
        end
        S_T1: begin
          // MDRin high means this T1 cycle already captured data, which also covers
          // data arriving on the very cycle the timeout is reached.
          if (MDRin) begin
            state  <= S_T2;
            MDRout <= 1'b1;
            IRin   <= 1'b1;
          end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            mem_fault <= 1'b1;
          end else begin
            Read     <= 1'b1;
            MDRin    <= mem_ready;
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_T2: begin
          state <= S_T3;
          cls   <= classify(opcode);
          if (classify(opcode) inside {C_BIN, C_MULDIV}) begin
            Rout <= onehot(rb);
            Yin  <= 1'b1;
          end
        end
        S_T3: begin
          if (cls == C_ILLEGAL) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            illegal <= 1'b1;
          end else begin
            state  <= S_T4;
            Zin    <= 1'b1;
            alu_op <= opcode;
            Rout   <= onehot((cls == C_UNARY) ? rb : rc);
          end
        end
        S_T4: begin
          state   <= S_T5;
          Zlowout <= 1'b1;
          if (cls == C_MULDIV) begin
            LOin <= 1'b1;
          end else begin
            Rin  <= onehot(ra);
            done <= 1'b1;
          end
        end
        S_T5: begin
          if (cls == C_MULDIV) begin
            state    <= S_T6;
            Zhighout <= 1'b1;
            HIin     <= 1'b1;
            done     <= 1'b1;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (retire) begin
        instr_count <= instr_count + COUNT_W'(1);
      end

      if (start) begin
        state <= S_T0;
        busy  <= 1'b1;
        PCout <= 1'b1;
        MARin <= 1'b1;
        IncPC <= 1'b1;
        Zin   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Directed bench: each instruction plan pushes per-cycle expected outputs plus the inputs
// to apply before that cycle's edge; the drain loop applies, samples on negedge and compares.
module tb_alu_instr_sequencer;

  localparam int DW = 32;
  localparam int RW = 4;
  localparam int OW = 5;
  localparam int TO = 15;
  localparam int CW = 16;
  localparam int NR = 2 ** RW;

  logic          Clock;
  logic          clear_n;
  logic          run;
  logic          mem_ready;
  logic [DW-1:0] ir_in;
  logic          PCout, Zhighout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin;
  logic          HIin, LOin, IncPC, Read, busy, done, illegal, mem_fault;
  logic [NR-1:0] Rin, Rout;
  logic [OW-1:0] alu_op;
  logic [CW-1:0] instr_count;

  alu_instr_sequencer #(
    .DATA_WIDTH(DW), .REG_SEL_W(RW), .OPC_W(OW), .MEM_TIMEOUT(TO), .COUNT_W(CW)
  ) dut (
    .Clock(Clock), .clear_n(clear_n), .run(run), .mem_ready(mem_ready), .ir_in(ir_in),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read), .Rin(Rin), .Rout(Rout),
    .alu_op(alu_op), .busy(busy), .done(done), .illegal(illegal),
    .mem_fault(mem_fault), .instr_count(instr_count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic          PCout, Zhighout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin;
    logic          HIin, LOin, IncPC, Read, busy, done, illegal, mem_fault;
    logic [NR-1:0] Rin, Rout;
    logic [OW-1:0] alu_op;
    logic [CW-1:0] instr_count;
  } vec_t;

  typedef struct {
    vec_t          exp;
    logic          mr;
    logic          rn;
    logic [DW-1:0] ir;
    int            tn;   // 0..6 = T-step, 9 = IDLE
  } step_t;

  step_t q[$];

  // Architectural model state carried between cycles.
  logic [OW-1:0] m_alu;
  logic          m_ill;
  logic          m_mf;
  logic [CW-1:0] m_cnt;

  int vectors;
  int miscompares;

  function automatic vec_t mk(input logic busy_v);
    vec_t v;
    v             = '0;
    v.busy        = busy_v;
    v.alu_op      = m_alu;
    v.illegal     = m_ill;
    v.mem_fault   = m_mf;
    v.instr_count = m_cnt;
    return v;
  endfunction

  task automatic push(input vec_t v, input logic mr, input logic rn, input logic [DW-1:0] ir,
                      input int tn);
    step_t s;
    s.exp = v;
    s.mr  = mr;
    s.rn  = rn;
    s.ir  = ir;
    s.tn  = tn;
    q.push_back(s);
  endtask

  task automatic check(input vec_t exp, input int tn);
    vec_t obs;
    obs = {PCout, Zhighout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
           HIin, LOin, IncPC, Read, busy, done, illegal, mem_fault,
           Rin, Rout, alu_op, instr_count};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL step%0d outputs: observed %h, expected %h", tn, obs, exp);
    end
    vectors++;
    assert (!((|Rin) && (|Rout))) else begin
      miscompares++;
      $error("FAIL step%0d rin_rout_exclusive: Rin=%h Rout=%h, one must be zero", tn, Rin, Rout);
    end
  endtask

  task automatic drain();
    step_t s;
    while (q.size() > 0) begin
      s         = q.pop_front();
      run       = s.rn;
      mem_ready = s.mr;
      ir_in     = s.ir;
      @(negedge Clock);
      check(s.exp, s.tn);
    end
  endtask

  // delay: T1 cycles without data before mem_ready (>= TO means never).
  // stop_at = 4 stops the plan after T4 (used for the mid-instruction reset).
  task automatic plan_instr(input logic [DW-1:0] ir, input int delay, input logic run_mid,
                            input logic run_after, input int stop_at);
    logic [OW-1:0] opc;
    logic [RW-1:0] ra, rb, rc;
    logic          md, un, ill;
    vec_t          v;
    opc = ir[31:27];
    ra  = ir[26:23];
    rb  = ir[22:19];
    rc  = ir[18:15];
    md  = (opc == 5'b01111) || (opc == 5'b10000);
    un  = (opc == 5'b10001) || (opc == 5'b10010);
    ill = !(md || un || (opc >= 5'b00011 && opc <= 5'b01010));

    v = mk(1'b1); v.PCout = 1'b1; v.MARin = 1'b1; v.IncPC = 1'b1; v.Zin = 1'b1;
    push(v, 1'b0, 1'b1, ir, 0);
    for (int i = 0; i < ((delay < TO) ? delay : TO); i++) begin
      v = mk(1'b1); v.Read = 1'b1;
      push(v, 1'b0, run_mid, ir, 1);
    end
    if (delay >= TO) begin
      m_mf = 1'b1;
      push(mk(1'b0), 1'b0, 1'b0, ir, 9);
      return;
    end
    v = mk(1'b1); v.Read = 1'b1; v.MDRin = 1'b1;
    push(v, 1'b1, run_mid, ir, 1);
    v = mk(1'b1); v.MDRout = 1'b1; v.IRin = 1'b1;
    push(v, 1'b0, run_mid, ir, 2);
    v = mk(1'b1);
    if (!ill && !un) begin
      v.Rout = 16'h0001 << rb;
      v.Yin  = 1'b1;
    end
    push(v, 1'b0, run_mid, ir, 3);
    if (ill) begin
      m_ill = 1'b1;
      push(mk(1'b0), 1'b0, 1'b0, ir, 9);
      return;
    end
    m_alu = opc;
    v = mk(1'b1); v.Zin = 1'b1; v.Rout = 16'h0001 << (un ? rb : rc);
    push(v, 1'b0, run_mid, ir, 4);
    if (stop_at == 4) return;
    v = mk(1'b1); v.Zlowout = 1'b1;
    if (md) begin
      v.LOin = 1'b1;
    end else begin
      v.Rin  = 16'h0001 << ra;
      v.done = 1'b1;
    end
    push(v, 1'b0, run_mid, ir, 5);
    if (md) begin
      v = mk(1'b1); v.Zhighout = 1'b1; v.HIin = 1'b1; v.done = 1'b1;
      push(v, 1'b0, run_mid, ir, 6);
    end
    m_cnt = m_cnt + 16'd1;
    if (!run_after) push(mk(1'b0), 1'b0, 1'b0, ir, 9);
  endtask

  task automatic model_reset();
    m_alu = '0;
    m_ill = 1'b0;
    m_mf  = 1'b0;
    m_cnt = '0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_reset();
    clear_n   = 1'b0;
    run       = 1'b0;
    mem_ready = 1'b0;
    ir_in     = '0;
    repeat (2) @(negedge Clock);
    check(mk(1'b0), 9);                          // held in reset
    clear_n = 1'b1;
    push(mk(1'b0), 1'b0, 1'b0, '0, 9);           // stays idle with run low
    drain();

    plan_instr(32'h28918000, 0,  1'b1, 1'b0, 0); // and R1,R2,R3, memory ready at once
    plan_instr(32'h18918000, 3,  1'b1, 1'b0, 0); // add, three wait cycles
    plan_instr(32'h20918000, TO, 1'b1, 1'b0, 0); // sub, memory never answers -> fault
    plan_instr(32'h28918000, TO - 1, 1'b1, 1'b0, 0); // data on the timeout cycle wins
    plan_instr(32'h78918000, 0,  1'b1, 1'b0, 0); // mul: LO then HI writeback
    plan_instr(32'h90900000, 0,  1'b1, 1'b0, 0); // not R1,R2
    plan_instr(32'hF8918000, 0,  1'b1, 1'b0, 0); // opcode 11111 -> illegal trap
    plan_instr(32'h40918000, 1,  1'b0, 1'b0, 0); // shl, run dropped mid-instruction
    plan_instr(32'h48918000, 0,  1'b1, 1'b1, 4); // ror, cut short by reset in T4
    drain();

    clear_n = 1'b0;                              // asynchronous reset mid-T4
    model_reset();
    #1;
    check(mk(1'b0), 4);
    run = 1'b0;
    @(negedge Clock);
    clear_n = 1'b1;

    plan_instr(32'h30888000, 0, 1'b1, 1'b1, 0);  // or R1,R1,R1 back-to-back
    plan_instr(32'h80918000, 2, 1'b1, 1'b1, 0);  // div
    plan_instr(32'h88900000, 0, 1'b1, 1'b0, 0);  // neg, then idle with count 3
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_instr_sequencer.md
Name: alu_instr_sequencer

Overview:
- Parametrised control-step sequencer for 3-register ALU instructions.
- Replaces hand-timed bench stimulus for the datapath with a clocked Moore FSM.
- Drives the datapath control strobes through fetch (T0–T2) and execute (T3–T6).
- Adds wait-stated memory reads with timeout, unary ops, HI/LO writeback for mul/div, illegal-opcode trap, continuous run mode and a retired-instruction counter.

Parameters:
- DATA_WIDTH, 32, width of the ir_in word.
- REG_SEL_W, 4, register field width; NUM_REGS = 2**REG_SEL_W.
- OPC_W, 5, opcode field width; opcode is ir_in[DATA_WIDTH-1 -: OPC_W].
- MEM_TIMEOUT, 15, maximum T1 wait cycles before fault.
- COUNT_W, 16, width of the retired-instruction counter.

Ports:
- Clock in 1: system clock, rising edge.
- clear_n in 1: asynchronous active-low reset.
- run in 1: level-sensitive; start or continue execution.
- mem_ready in 1: memory data valid during T1.
- ir_in in DATA_WIDTH: IR contents. Fields: ra = [DW-OPC_W-1 -: REG_SEL_W], rb = next REG_SEL_W bits, rc = next REG_SEL_W bits.
- PCout, Zhighout, Zlowout, MDRout out 1 each: bus drivers.
- MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin out 1 each: register loads.
- IncPC, Read out 1 each: PC increment and memory read.
- Rin out NUM_REGS: one-hot register load.
- Rout out NUM_REGS: one-hot register drive.
- alu_op out OPC_W: opcode presented to the ALU.
- busy out 1: FSM not in IDLE.
- done out 1: one-cycle pulse in the final execute step.
- illegal out 1: sticky; unsupported opcode seen.
- mem_fault out 1: sticky; T1 timeout.
- instr_count out COUNT_W: retired instructions.

Behaviour:
- Reset: clear_n low asynchronously forces state IDLE and every output to 0, including instr_count and both sticky flags. This applies mid-instruction; no partial step completes.
- Output timing: all outputs are registered and decoded from the state register. Each state lasts exactly one clock, except T1.
- Opcode classes:
  - Binary: add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01000, ror 01001, rol 01010.
  - Mul/div: mul 01111, div 10000.
  - Unary: neg 10001, not 10010.
  - All others are illegal.
- IDLE: if run = 1, go to T0; else stay.
- T0: PCout, MARin, IncPC, Zin = 1. Next state T1.
- T1: Read = 1 every cycle; wait counter increments each cycle.
  - mem_ready = 1: MDRin = 1 that cycle, then go to T2.
  - Counter reaches MEM_TIMEOUT with mem_ready still 0: set mem_fault, go to IDLE.
  - mem_ready = 1 in the same cycle the timeout is reached: mem_ready wins; no fault.
- T2: MDRout, IRin = 1. Next state T3.
- T3: decode opcode from ir_in (ir_in must be stable from T3 onward).
  - Illegal: set illegal, go to IDLE; no register write, no done, no count.
  - Unary: idle cycle, then T4.
  - Otherwise: Rout[rb] = 1, Yin = 1, then T4.
- T4: Zin = 1, alu_op = opcode.
  - Unary: Rout[rb] = 1.
  - Otherwise: Rout[rc] = 1.
  - alu_op holds its value until the next T4 or reset.
- T5:
  - Binary/unary: Zlowout, Rin[ra] = 1, done = 1.
  - Mul/div: Zlowout, LOin = 1.
- T6 (mul/div only): Zhighout, HIin, done = 1.
- After done: instr_count increments, wrapping modulo 2**COUNT_W. Then go to T0 if run = 1, else IDLE.
- run dropping mid-instruction does not abort; the current instruction completes.
- Sticky flags clear only on reset. A new run after a fault restarts at T0.
- Rin and Rout are never both non-zero in the same cycle.
- ra == rb == rc is legal; no special handling.

Test Plan:
- Reset, run = 1, mem_ready tied 1, ir_in = 32'h28918000 (and R1,R2,R3):
  - T0–T5 complete in 6 cycles.
  - T3: Rout = 16'h0004. T4: Rout = 16'h0008, alu_op = 5'b00101. T5: Rin = 16'h0002, done = 1.
  - instr_count = 1.
- mem_ready delayed 3 cycles: Read high for 4 T1 cycles, MDRin high only in the 4th. With MEM_TIMEOUT = 15 and mem_ready never rising: mem_fault = 1, busy = 0 after 15 T1 cycles.
- ir_in = 32'h78918000 (mul): T5 has LOin = 1 with Rin = 0; T6 has Zhighout, HIin, done = 1; count increments once.
- ir_in = 32'h90900000 (not R1,R2): T3 has no Yin or Rout; T4 has Rout = 16'h0004 and alu_op = 5'b10010.
- Opcode 11111: illegal = 1 after T3, return to IDLE, instr_count unchanged.
- Assert clear_n = 0 during T4: all outputs 0 immediately. Run held 1 with 3 back-to-back instructions: count = 3, no IDLE cycle between them.
